// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: control encodings and engine states.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;
  localparam logic [3:0] ALU_MULTU = 4'b1000;
  localparam logic [3:0] ALU_DIVU  = 4'b1001;
  localparam logic [3:0] ALU_MFHI  = 4'b1010;
  localparam logic [3:0] ALU_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply / restoring divide engine; owns HI/LO, the
// iteration counter and busy. HI/LO double as the working registers.
//
// state | meaning
// IDLE  | no operation in flight, HI/LO hold architectural values
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go_mul,
  input  logic             go_div,
  input  logic             go_dz,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             busy,
  output logic             last
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic             ge;

  assign sum     = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
  assign shifted = {hi, lo[WIDTH-1]};
  assign ge      = shifted >= {1'b0, m};
  assign last    = busy && (cnt == '0);

  always_comb begin
    hi_nxt = hi;
    lo_nxt = lo;
    case (state)
      MUL: begin
        hi_nxt = sum[WIDTH:1];
        lo_nxt = {sum[0], lo[WIDTH-1:1]};
      end
      DIV: begin
        hi_nxt = ge ? (shifted[WIDTH-1:0] - m) : shifted[WIDTH-1:0];
        lo_nxt = {lo[WIDTH-2:0], ge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (go_mul || go_div) begin
            hi    <= '0;
            lo    <= go_mul ? b : a;
            m     <= go_mul ? a : b;
            cnt   <= CNT_W'(WIDTH - 1);
            busy  <= 1'b1;
            state <= go_mul ? MUL : DIV;
          end else if (go_dz) begin
            hi <= a;
            lo <= '1;
          end
        end
        MUL, DIV: begin
          hi <= hi_nxt;
          lo <= lo_nxt;
          if (cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered EX-stage ALU: single-cycle logic/arith ops plus iterative MULTU/DIVU
// behind a start/busy/done handshake.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] read1,
  input  logic [WIDTH-1:0] read2,
  input  logic [3:0]       control,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  logic             accept;
  logic             b_zero;
  logic             multi;
  logic             last;
  logic [WIDTH-1:0] hi, lo, lo_nxt;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;

  assign accept = start && !busy;
  assign b_zero = (read2 == '0);
  assign multi  = (control == ALU_MULTU) || (control == ALU_DIVU && !b_zero);
  assign sum    = read1 + read2;
  assign diff   = read1 - read2;

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .go_mul (accept && control == ALU_MULTU),
    .go_div (accept && control == ALU_DIVU && !b_zero),
    .go_dz  (accept && control == ALU_DIVU && b_zero),
    .a      (read1),
    .b      (read2),
    .hi     (hi),
    .lo     (lo),
    .lo_nxt (lo_nxt),
    .busy   (busy),
    .last   (last)
  );

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control)
      ALU_AND: alu_res = read1 & read2;
      ALU_OR:  alu_res = read1 | read2;
      ALU_ADD: begin
        alu_res = sum;
        alu_ovf = (read1[WIDTH-1] == read2[WIDTH-1]) && (sum[WIDTH-1] != read1[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ovf = (read1[WIDTH-1] != read2[WIDTH-1]) && (diff[WIDTH-1] != read1[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(read1) < $signed(read2)};
      ALU_NOR:  alu_res = ~(read1 | read2);
      ALU_DIVU: alu_res = '1;  // only reaches here with a zero divisor
      ALU_MFHI: alu_res = hi;
      ALU_MFLO: alu_res = lo;
      default:  alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (last) begin
        result <= lo_nxt;
        zero   <= (lo_nxt == '0);
        done   <= 1'b1;
      end else if (accept) begin
        overflow <= 1'b0;
        div_zero <= 1'b0;
        if (!multi) begin
          result   <= alu_res;
          zero     <= (alu_res == '0);
          overflow <= alu_ovf;
          div_zero <= (control == ALU_DIVU);
          done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed vector table, multi-cycle
// corner sequences and randomized ops against an arithmetic reference model.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] read1, read2;
  logic [3:0]  control;
  logic [31:0] result;
  logic        zero, overflow, div_zero, busy, done;

  int total = 0;
  int bad = 0;
  int lat, busy_cnt;
  logic [31:0] hi_m, lo_m;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .read1(read1), .read2(read2),
    .control(control), .result(result), .zero(zero), .overflow(overflow),
    .div_zero(div_zero), .busy(busy), .done(done)
  );

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a, b, r;
    logic        z, ov;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one op, optionally poke start mid-busy; returns latency to done.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input bit poke);
    @(negedge clk);
    control = c; read1 = a; read2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; read1 = $urandom; read2 = $urandom;
    lat = 1; busy_cnt = 0;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (poke && (lat == 5 || lat == 20)) begin
        start = 1'b1; control = 4'b0010; read1 = $urandom; read2 = $urandom;
      end
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    if (!done) check("done_timeout", 32'(lat), 32'd33);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output bit ov, output bit dz, output int l);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    r = 32'd0; ov = 1'b0; dz = 1'b0; l = 1;
    case (c)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin r = a + b; s = sa + sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0110: begin r = a - b; s = sa - sb; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1000: begin p = {32'd0, a} * {32'd0, b}; hi_m = p[63:32]; lo_m = p[31:0]; r = lo_m; l = 33; end
      4'b1001: begin
        if (b == 0) begin hi_m = a; lo_m = 32'hFFFF_FFFF; dz = 1'b1; end
        else begin lo_m = a / b; hi_m = a % b; l = 33; end
        r = lo_m;
      end
      4'b1010: r = hi_m;
      4'b1011: r = lo_m;
      default: r = 32'd0;
    endcase
  endtask

  task automatic run_checked(input string tag, input logic [3:0] c, input logic [31:0] a,
                             input logic [31:0] b, input bit poke);
    logic [31:0] r; bit ov, dz; int l;
    model(c, a, b, r, ov, dz, l);
    issue(c, a, b, poke);
    check({tag, "_result"}, result, r);
    check({tag, "_zero"}, 32'(zero), 32'(r == 0));
    check({tag, "_ovf"}, 32'(overflow), 32'(ov));
    check({tag, "_divzero"}, 32'(div_zero), 32'(dz));
    check({tag, "_latency"}, 32'(lat), 32'(l));
    check({tag, "_busycycles"}, 32'(busy_cnt), (l == 33) ? 32'd32 : 32'd0);
  endtask

  vec_t vecs[$];
  logic [3:0] ops[14] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000,
                          4'b1001, 4'b1010, 4'b1011, 4'b0011, 4'b1101, 4'b1000, 4'b1001};

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 15));
      2: return 32'h8000_0000 ^ 32'($urandom_range(0, 1));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; read1 = 0; read2 = 0; control = 0;
    hi_m = 0; lo_m = 0;
    vecs = '{
      '{4'b0000, 32'd50, 32'd30, 32'd18, 1'b0, 1'b0},
      '{4'b0001, 32'd50, 32'd30, 32'd62, 1'b0, 1'b0},
      '{4'b0010, 32'd50, 32'd30, 32'd80, 1'b0, 1'b0},
      '{4'b0110, 32'd50, 32'd30, 32'd20, 1'b0, 1'b0},
      '{4'b1100, 32'd50, 32'd30, 32'hFFFF_FFC1, 1'b0, 1'b0},
      '{4'b0111, 32'hFFFF_FFFB, 32'd3, 32'd1, 1'b0, 1'b0},
      '{4'b0111, 32'd3, 32'hFFFF_FFFB, 32'd0, 1'b1, 1'b0},
      '{4'b0110, 32'd30, 32'd30, 32'd0, 1'b1, 1'b0},
      '{4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b1},
      '{4'b0110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1},
      '{4'b0000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0},
      '{4'b1111, 32'd5, 32'd6, 32'd0, 1'b1, 1'b0}
    };
    repeat (2) @(negedge clk);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", {30'd0, overflow, div_zero}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].c, vecs[i].a, vecs[i].b, 1'b0);
      check($sformatf("vec%0d_result", i), result, vecs[i].r);
      check($sformatf("vec%0d_zero", i), 32'(zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ov));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
      check($sformatf("vec%0d_busy", i), 32'(busy_cnt), 32'd0);
    end

    // MULTU with stray starts mid-busy, then HI read back right after done
    issue(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b1);
    check("multu_lat", 32'(lat), 32'd33);
    check("multu_busy", 32'(busy_cnt), 32'd32);
    check("multu_lo", result, 32'hFFFF_FFFE);
    control = 4'b1010; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("mfhi_after_mul", result, 32'd1);
    check("mfhi_done", 32'(done), 32'd1);

    issue(4'b1001, 32'd50, 32'd30, 1'b0);
    check("divu_lo", result, 32'd1);
    check("divu_busy", 32'(busy_cnt), 32'd32);
    issue(4'b1010, 32'd0, 32'd0, 1'b0);
    check("divu_hi", result, 32'd20);

    issue(4'b1001, 32'd7, 32'd0, 1'b0);
    check("dz_result", result, 32'hFFFF_FFFF);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_lat", 32'(lat), 32'd1);
    issue(4'b1010, 32'd0, 32'd0, 1'b0);
    check("dz_hi", result, 32'd7);
    check("dz_cleared", 32'(div_zero), 32'd0);

    // reset mid-MULTU aborts without a done pulse
    @(negedge clk);
    control = 4'b1000; read1 = 32'd123; read2 = 32'd456; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    hi_m = 0; lo_m = 0;
    run_checked("abort_add", 4'b0010, 32'd2, 32'd3, 1'b0);
    check("abort_add5", result, 32'd5);
    run_checked("abort_hi", 4'b1010, 32'd0, 32'd0, 1'b0);
    run_checked("abort_lo", 4'b1011, 32'd0, 32'd0, 1'b0);

    for (int n = 0; n < 150; n++)
      run_checked($sformatf("rnd%0d", n), ops[$urandom_range(0, 13)], pick(), pick(),
                  bit'($urandom_range(0, 3) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
